// File: rtl/veda_pkg.sv
// Shared definitions for the veda_ram block: read-during-write mode encoding
// and the controller state type.
package veda_pkg;

    localparam logic MODE_WRITE_FIRST = 1'b0;
    localparam logic MODE_READ_FIRST  = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/veda_byte_merge.sv
// Per-byte write merge: each byte of the result comes from the new word when
// its enable bit is set, otherwise from the stored word.
module veda_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    // NOTE: combinational blocks assign a full default first so no latch is inferred.
    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (be_i[b]) begin
                merged_o[8*b +: 8] = new_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/veda_ram.sv
// Single-port byte-maskable RAM with a registered response, selectable
// read-during-write behaviour, range checking and a zeroing sweep after reset.
module veda_ram
    import veda_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic                req,
    input  logic                write_enable,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                clear_req,
    output logic                ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                err
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  PTR_LAST  = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_e            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              err_q;

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] data_out_d;
    logic              wr_en;

    assign ready    = (state_q == ST_IDLE);
    assign accept   = req && ready;
    assign in_range = ({1'b0, address} < DEPTH_EXT);
    assign idx      = address[IDX_W-1:0];
    assign old_word = in_range ? mem_q[idx] : '0;
    assign wr_en    = accept && write_enable && in_range;

    veda_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_i    (old_word),
        .new_i    (data_in),
        .be_i     (byte_en),
        .merged_o (merged_word)
    );

    always_comb begin
        data_out_d = '0;
        if (in_range) begin
            data_out_d = (write_enable && mode == MODE_WRITE_FIRST) ? merged_word : old_word;
        end
    end

    // NOTE: the storage array has no reset; the post-reset sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= merged_word;
        end
    end

    // Controller and registered response; a request on the clear_req edge is
    // still served because acceptance only looks at the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= accept;
            err_q      <= accept && !in_range;
            if (accept) begin
                data_out_q <= data_out_d;
            end
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_veda_ram.sv
// Self-checking bench for veda_ram: directed literal checks plus a randomized
// run compared every cycle against a behavioural array model.
module tb_veda_ram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 6;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mode = 1'b0;
    logic              req = 1'b0;
    logic              write_enable = 1'b0;
    logic [BE_W-1:0]   byte_en = '0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              clear_req = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    veda_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .req          (req),
        .write_enable (write_enable),
        .byte_en      (byte_en),
        .address      (address),
        .data_in      (data_in),
        .clear_req    (clear_req),
        .ready        (ready),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array plus a count of sweep cycles still to run.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_sweep = DEPTH;
    logic              m_rv = 1'b0;
    logic              m_err = 1'b0;
    logic [DATA_W-1:0] m_data = '0;

    always @(posedge clk or posedge reset) begin : model
        logic [DATA_W-1:0] mo;
        logic [DATA_W-1:0] mn;
        if (reset) begin
            m_sweep <= DEPTH;
            m_rv    <= 1'b0;
            m_err   <= 1'b0;
            m_data  <= '0;
        end else if (m_sweep > 0) begin
            m_mem[DEPTH - m_sweep] <= '0;
            m_sweep <= m_sweep - 1;
            m_rv    <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_rv  <= req;
            m_err <= req && (int'(address) >= DEPTH);
            if (req) begin
                if (int'(address) >= DEPTH) begin
                    m_data <= '0;
                end else begin
                    mo = m_mem[address[4:0]];
                    mn = mo;
                    for (int b = 0; b < BE_W; b++) begin
                        if (byte_en[b]) mn[8*b +: 8] = data_in[8*b +: 8];
                    end
                    if (!write_enable) m_data <= mo;
                    else m_data <= mode ? mo : mn;
                    if (write_enable) m_mem[address[4:0]] <= mn;
                end
            end
            if (clear_req) m_sweep <= DEPTH;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",    {63'd0, ready},    {63'd0, (m_sweep == 0)});
            check("rd_valid", {63'd0, rd_valid}, {63'd0, m_rv});
            check("err",      {63'd0, err},      {63'd0, m_err});
            check("data_out", {32'd0, data_out}, {32'd0, m_data});
        end
    end

    // Called at a negedge; returns at the next negedge with the response visible.
    task automatic op(input logic m, input logic we, input logic [BE_W-1:0] be,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic clr);
        mode = m; req = 1'b1; write_enable = we; byte_en = be;
        address = a; data_in = d; clear_req = clr;
        @(negedge clk);
        req = 1'b0; write_enable = 1'b0; clear_req = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    // Expects the first sweep edge to be ahead: ready low for DEPTH negedges, then high.
    task automatic expect_sweep(input string name);
        check({name, "_ready_low"}, {63'd0, ready}, 64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) check({name, "_ready_low"}, {63'd0, ready}, 64'd0);
        end
        @(negedge clk);
        check({name, "_ready_high"}, {63'd0, ready}, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("reset_data_out", {32'd0, data_out}, 64'd0);
        reset = 1'b0;
        expect_sweep("post_reset");

        op(1'b0, 1'b0, 4'h0, 6'd5, 32'h0, 1'b0);
        check("read5_valid", {63'd0, rd_valid}, 64'd1);
        check("read5_data",  {32'd0, data_out}, 64'h0);

        op(1'b0, 1'b1, 4'hF, 6'd0, 32'h42BA8000, 1'b0);
        check("wf_write", {32'd0, data_out}, 64'h42BA8000);
        op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0);
        check("wf_read", {32'd0, data_out}, 64'h42BA8000);

        op(1'b1, 1'b1, 4'hF, 6'd0, 32'h414D0000, 1'b0);
        check("rf_write", {32'd0, data_out}, 64'h42BA8000);
        op(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0);
        check("rf_read", {32'd0, data_out}, 64'h414D0000);

        op(1'b0, 1'b1, 4'b0011, 6'd0, 32'h0000FFFF, 1'b0);
        check("byte_merge", {32'd0, data_out}, 64'h414DFFFF);

        op(1'b0, 1'b1, 4'hF, 6'd8, 32'h12345678, 1'b0);
        op(1'b0, 1'b1, 4'hF, 6'd40, 32'hFFFFFFFF, 1'b0);
        check("oor_err",   {63'd0, err},      64'd1);
        check("oor_valid", {63'd0, rd_valid}, 64'd1);
        check("oor_data",  {32'd0, data_out}, 64'h0);
        op(1'b0, 1'b0, 4'h0, 6'd8, 32'h0, 1'b0);
        check("addr8_intact", {32'd0, data_out}, 64'h12345678);
        check("addr8_no_err", {63'd0, err},      64'd0);

        for (int w = 0; w < 4; w++) op(1'b0, 1'b1, 4'hF, 6'(w), 32'hA5A50000 + 32'(w), 1'b0);
        pulse_clear();
        expect_sweep("clear");
        for (int w = 0; w < 4; w++) begin
            op(1'b0, 1'b0, 4'h0, 6'(w), 32'h0, 1'b0);
            check("cleared_word", {32'd0, data_out}, 64'h0);
        end

        // Request and clear on the same edge: write is served, then the sweep wipes it.
        op(1'b0, 1'b1, 4'hF, 6'd2, 32'hCAFEF00D, 1'b1);
        check("req_with_clear", {32'd0, data_out}, 64'hCAFEF00D);
        expect_sweep("req_clear");
        op(1'b0, 1'b0, 4'h0, 6'd2, 32'h0, 1'b0);
        check("req_clear_wiped", {32'd0, data_out}, 64'h0);

        op(1'b0, 1'b1, 4'hF, 6'd31, 32'hDEADBEEF, 1'b0);
        pulse_clear();
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("midsweep_reset_valid", {63'd0, rd_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_sweep("midsweep_reset");
        op(1'b0, 1'b0, 4'h0, 6'd31, 32'h0, 1'b0);
        check("last_word_cleared", {32'd0, data_out}, 64'h0);

        for (int i = 0; i < 3000; i++) begin
            mode         = 1'($urandom_range(0, 1));
            req          = ($urandom_range(0, 3) != 0);
            write_enable = 1'($urandom_range(0, 1));
            byte_en      = 4'($urandom_range(0, 15));
            address      = 6'($urandom_range(0, 39));
            data_in      = $urandom;
            clear_req    = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        req = 1'b0; clear_req = 1'b0; write_enable = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/veda_ram.md
VEDA_RAM -- requirements
Module: veda_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32, number of words; must be at least 2.
REQ-003 SHALL have parameter ADDR_W, default 6, address width; must satisfy 2**ADDR_W >= DEPTH.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port mode, input, 1 bit, read-during-write select: 0 = write-first, 1 = read-first.
REQ-007 SHALL have port req, input, 1 bit, access request.
REQ-008 SHALL have port write_enable, input, 1 bit, write qualifier for the request.
REQ-009 SHALL have port byte_en, input, DATA_W/8 bits, per-byte write mask.
REQ-010 SHALL have port address, input, ADDR_W bits, word address.
REQ-011 SHALL have port data_in, input, DATA_W bits, write data.
REQ-012 SHALL have port clear_req, input, 1 bit, requests a zero sweep of the whole array.
REQ-013 SHALL have port ready, output, 1 bit, high when a request can be accepted.
REQ-014 SHALL have port data_out, output, DATA_W bits, registered response word.
REQ-015 SHALL have port rd_valid, output, 1 bit, one-cycle pulse qualifying data_out.
REQ-016 SHALL have port err, output, 1 bit, one-cycle pulse, coincident with rd_valid, flagging an out-of-range address.

Function
REQ-017 SHALL implement a two-state FSM {CLEAR, IDLE}, with ready = (state == IDLE).
REQ-018 In CLEAR, SHALL write zero to word ptr each cycle and increment ptr from 0 to DEPTH-1, then enter IDLE; a sweep lasts exactly DEPTH cycles.
REQ-019 In IDLE, SHALL leave IDLE for CLEAR with ptr = 0 on the edge where clear_req is 1; a clear_req asserted while in CLEAR SHALL be ignored.
REQ-020 SHALL accept a request on the edge where req and ready are both 1; req while ready is 0 SHALL be dropped, with no write and no response.
REQ-021 If a request and clear_req arrive on the same edge, SHALL serve the request first; the sweep starts on the following cycle.
REQ-022 SHALL drive data_out and rd_valid=1 on the cycle after acceptance (latency 1); data_out SHALL hold its value when rd_valid is 0.
REQ-023 When write_enable is 1, SHALL update only the bytes whose byte_en bit is 1; the other bytes keep their stored value.
REQ-024 With mode 0 and a write, data_out SHALL be the merged new word; with mode 1 and a write, data_out SHALL be the pre-write word.
REQ-025 With write_enable 0, SHALL perform a plain read in either mode.
REQ-026 With address >= DEPTH, SHALL perform no write and SHALL respond with err=1, rd_valid=1 and data_out=0.
REQ-027 Back-to-back requests to the same address SHALL observe the previous write: full throughput, one request per cycle.

Reset
REQ-028 On reset, SHALL asynchronously force state=CLEAR, ptr=0, data_out=0, rd_valid=0 and err=0.
REQ-029 SHALL keep ready at 0 throughout reset and throughout the following DEPTH-cycle sweep.
REQ-030 An assertion of reset mid-sweep or mid-request SHALL abort the operation and restart the sweep from ptr=0 when reset is released.

Structure
REQ-031 SHALL place the mode constants (MODE_WRITE_FIRST=0, MODE_READ_FIRST=1) and the state typedef in the shared package veda_pkg.
REQ-032 SHALL implement the byte-enable merge in one combinational sub-module, veda_byte_merge, parametrised by DATA_W.

Verification
REQ-033 Release reset; check ready=0 for 32 cycles, then ready=1; read address 5 -> rd_valid=1, data_out=0x00000000.
REQ-034 mode=0, write 0x42BA8000 to address 0 with byte_en=1111 -> next cycle data_out=0x42BA8000; then read address 0 -> 0x42BA8000.
REQ-035 mode=1, write 0x414D0000 to address 0 holding 0x42BA8000 -> data_out=0x42BA8000; then read address 0 -> 0x414D0000.
REQ-036 mode=0, write 0x0000FFFF with byte_en=0011 to a word holding 0x414D0000 -> data_out=0x414DFFFF.
REQ-037 Request address 40 (DEPTH=32) -> err=1, rd_valid=1, data_out=0; a following read at address 8 returns its unmodified contents.
REQ-038 Pulse clear_req after filling words 0..3 -> ready=0 for 32 cycles, then all words read as 0; assert reset at sweep cycle 10 -> the sweep restarts and ready rises 32 cycles after release.
